// File: rtl/bus_mailbox.sv
// ---------------------------------------------------------------------------
// bus_mailbox
//
// External-bus responder giving the 6502 a byte-wide bidirectional mailbox
// to an on-board host stream. Two FIFOs are provided:
//   H2C: host pushes with valid/ready, CPU pops by reading DATA.
//   C2H: CPU pushes by writing DATA, host drains with valid/ready.
// Register window (offset from BASE_ADDR):
//   +0 DATA    read pops H2C head, write pushes C2H
//   +1 STATUS  {3'b0, underflow, overflow, c2h_empty, c2h_full, h2c_nonempty}
//              write 1 to bit3/bit4 clears the matching sticky flag
//   +2 IRQ_EN  bit0 = irq on H2C non-empty, bit1 = irq on C2H empty
//   +3 COUNT   H2C occupancy (read only)
//
// Ports:
//   i_clk, i_reset_n          clock and synchronous active-low reset
//   i_phi2, i_addr, i_rw,     CPU bus as seen on the MCU external pins
//   i_data
//   o_data, o_sel             combinational read data and window decode
//   i_h2c_data/valid,         host -> CPU stream
//   o_h2c_ready
//   o_c2h_data/valid,         CPU -> host stream
//   i_c2h_ready
//   o_irq                     registered level interrupt request
// ---------------------------------------------------------------------------
module bus_mailbox #(
   parameter logic [15:0] BASE_ADDR  = 16'hB000,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_phi2,
   input  logic [15:0] i_addr,
   input  logic        i_rw,
   input  logic [7:0]  i_data,
   output logic [7:0]  o_data,
   output logic        o_sel,
   input  logic [7:0]  i_h2c_data,
   input  logic        i_h2c_valid,
   output logic        o_h2c_ready,
   output logic [7:0]  o_c2h_data,
   output logic        o_c2h_valid,
   input  logic        i_c2h_ready,
   output logic        o_irq
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   // FIFO storage (no reset needed: pointers/counts define validity)
   logic [7:0]    h2c_mem [FIFO_DEPTH];
   logic [7:0]    c2h_mem [FIFO_DEPTH];

   logic [AW-1:0] h2c_wr_ptr_reg, h2c_wr_ptr_next;
   logic [AW-1:0] h2c_rd_ptr_reg, h2c_rd_ptr_next;
   logic [CW-1:0] h2c_count_reg,  h2c_count_next;
   logic [AW-1:0] c2h_wr_ptr_reg, c2h_wr_ptr_next;
   logic [AW-1:0] c2h_rd_ptr_reg, c2h_rd_ptr_next;
   logic [CW-1:0] c2h_count_reg,  c2h_count_next;
   logic          overflow_reg,   overflow_next;
   logic          underflow_reg,  underflow_next;
   logic [1:0]    irq_en_reg,     irq_en_next;
   logic          irq_reg,        irq_next;
   logic          phi2_q_reg;
   logic          run_reg;        // low until the first edge after reset release

   // Address decode: subtracting the base makes the window test a single
   // unsigned compare.
   logic [15:0]   addr_off;
   logic [1:0]    reg_off;

   logic h2c_full, h2c_empty, c2h_full, c2h_empty;
   logic commit;
   logic cpu_rd_data, cpu_wr_data, status_wr, irq_en_wr;
   logic h2c_push, h2c_pop, c2h_push, c2h_pop;
   logic overflow_set, underflow_set;
   logic [7:0] status_val;

   assign addr_off = i_addr - BASE_ADDR;
   assign o_sel    = (addr_off < 16'd4);
   assign reg_off  = addr_off[1:0];

   assign h2c_full  = (h2c_count_reg == CW'(FIFO_DEPTH));
   assign h2c_empty = (h2c_count_reg == '0);
   assign c2h_full  = (c2h_count_reg == CW'(FIFO_DEPTH));
   assign c2h_empty = (c2h_count_reg == '0);

   assign o_h2c_ready = i_reset_n && run_reg && !h2c_full;
   assign o_c2h_valid = i_reset_n && !c2h_empty;
   assign o_c2h_data  = c2h_mem[c2h_rd_ptr_reg];
   assign o_irq       = irq_reg;

   // One commit per bus cycle: only the clk edge that first sees phi2 low
   // after it was high qualifies, no matter how long phi2 was high.
   assign commit = i_reset_n && phi2_q_reg && !i_phi2 && o_sel;

   assign cpu_rd_data = commit &&  i_rw && (reg_off == 2'd0);
   assign cpu_wr_data = commit && !i_rw && (reg_off == 2'd0);
   assign status_wr   = commit && !i_rw && (reg_off == 2'd1);
   assign irq_en_wr   = commit && !i_rw && (reg_off == 2'd2);

   // All decisions use pre-edge state: a full FIFO never accepts even if
   // it is being popped in the same cycle.
   assign h2c_push      = i_h2c_valid && o_h2c_ready;
   assign h2c_pop       = cpu_rd_data && !h2c_empty;
   assign underflow_set = cpu_rd_data &&  h2c_empty;
   assign c2h_push      = cpu_wr_data && !c2h_full;
   assign overflow_set  = cpu_wr_data &&  c2h_full;
   assign c2h_pop       = o_c2h_valid && i_c2h_ready;

   assign status_val = {3'b000, underflow_reg, overflow_reg,
                        c2h_empty, c2h_full, !h2c_empty};

   // Read mux: current state only, no preview of a pending pop.
   always_comb begin
      o_data = 8'h00;
      if (o_sel && i_rw) begin
         case (reg_off)
            2'd0:    o_data = h2c_empty ? 8'h00 : h2c_mem[h2c_rd_ptr_reg];
            2'd1:    o_data = status_val;
            2'd2:    o_data = {6'b000000, irq_en_reg};
            default: o_data = 8'(h2c_count_reg);
         endcase
      end
   end

   always_comb begin
      h2c_wr_ptr_next = h2c_wr_ptr_reg + AW'(h2c_push);
      h2c_rd_ptr_next = h2c_rd_ptr_reg + AW'(h2c_pop);
      h2c_count_next  = h2c_count_reg + CW'(h2c_push) - CW'(h2c_pop);
      c2h_wr_ptr_next = c2h_wr_ptr_reg + AW'(c2h_push);
      c2h_rd_ptr_next = c2h_rd_ptr_reg + AW'(c2h_pop);
      c2h_count_next  = c2h_count_reg + CW'(c2h_push) - CW'(c2h_pop);

      overflow_next  = (overflow_reg  && !(status_wr && i_data[3])) || overflow_set;
      underflow_next = (underflow_reg && !(status_wr && i_data[4])) || underflow_set;
      irq_en_next    = irq_en_wr ? i_data[1:0] : irq_en_reg;

      // IRQ reflects the state after this edge, hence the _next terms.
      irq_next = (irq_en_next[0] && (h2c_count_next != '0)) ||
                 (irq_en_next[1] && (c2h_count_next == '0));
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         h2c_wr_ptr_reg <= '0;
         h2c_rd_ptr_reg <= '0;
         h2c_count_reg  <= '0;
         c2h_wr_ptr_reg <= '0;
         c2h_rd_ptr_reg <= '0;
         c2h_count_reg  <= '0;
         overflow_reg   <= 1'b0;
         underflow_reg  <= 1'b0;
         irq_en_reg     <= 2'b00;
         irq_reg        <= 1'b0;
         phi2_q_reg     <= 1'b0;
         run_reg        <= 1'b0;
      end else begin
         h2c_wr_ptr_reg <= h2c_wr_ptr_next;
         h2c_rd_ptr_reg <= h2c_rd_ptr_next;
         h2c_count_reg  <= h2c_count_next;
         c2h_wr_ptr_reg <= c2h_wr_ptr_next;
         c2h_rd_ptr_reg <= c2h_rd_ptr_next;
         c2h_count_reg  <= c2h_count_next;
         overflow_reg   <= overflow_next;
         underflow_reg  <= underflow_next;
         irq_en_reg     <= irq_en_next;
         irq_reg        <= irq_next;
         phi2_q_reg     <= i_phi2;
         run_reg        <= 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (h2c_push) begin
         h2c_mem[h2c_wr_ptr_reg] <= i_h2c_data;
      end
      if (c2h_push) begin
         c2h_mem[c2h_wr_ptr_reg] <= i_data;
      end
   end

endmodule

// File: tb/tb_bus_mailbox.sv
// ---------------------------------------------------------------------------
// tb_bus_mailbox
//
// Directed scenarios followed by randomized traffic. A queue-based reference
// model tracks both FIFOs, the sticky flags, IRQ_EN and the expected IRQ
// level; every clock the DUT outputs are compared against it.
// ---------------------------------------------------------------------------
module tb_bus_mailbox;

   localparam int          DEPTH = 8;
   localparam logic [15:0] BASE  = 16'hB000;

   logic        clk = 1'b0;
   logic        reset_n, phi2, rw;
   logic [15:0] addr;
   logic [7:0]  wdata, o_data;
   logic        o_sel;
   logic [7:0]  h2c_data;
   logic        h2c_valid, o_h2c_ready;
   logic [7:0]  o_c2h_data;
   logic        o_c2h_valid, c2h_ready, o_irq;

   bus_mailbox #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
      .i_clk       (clk),
      .i_reset_n   (reset_n),
      .i_phi2      (phi2),
      .i_addr      (addr),
      .i_rw        (rw),
      .i_data      (wdata),
      .o_data      (o_data),
      .o_sel       (o_sel),
      .i_h2c_data  (h2c_data),
      .i_h2c_valid (h2c_valid),
      .o_h2c_ready (o_h2c_ready),
      .o_c2h_data  (o_c2h_data),
      .o_c2h_valid (o_c2h_valid),
      .i_c2h_ready (c2h_ready),
      .o_irq       (o_irq)
   );

   always #5 clk = ~clk;

   // ---------------- reference model state ----------------
   logic [7:0] h2c_q[$];
   logic [7:0] c2h_q[$];
   logic [7:0] host_rx[$];
   bit         ovf, unf, run, phi2_prev, exp_irq, model_valid, rand_host;
   bit [1:0]   irq_en;
   logic [7:0] last_rdata, bus_rd;
   bit         last_push_h;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock: compare outputs against the model, then advance the model
   // by the register-map and handshake rules using pre-edge state.
   task automatic tick();
      bit h_ready, c_valid, sel, commit, push_h, pop_c;
      bit cpu_pop, cpu_push, set_unf, set_ovf, st_wr, en_wr;
      logic [15:0] off16;
      logic [1:0]  off;
      logic [7:0]  exp_rd, st;
      if (rand_host) begin
         h2c_valid = 1'($urandom_range(0, 1));
         h2c_data  = 8'($urandom);
         c2h_ready = 1'($urandom_range(0, 1));
      end
      #1;
      h_ready = reset_n && run && (h2c_q.size() < DEPTH);
      c_valid = reset_n && (c2h_q.size() != 0);
      off16   = addr - BASE;
      sel     = (off16 < 4);
      off     = off16[1:0];
      st      = {3'b000, unf, ovf, c2h_q.size() == 0, c2h_q.size() == DEPTH, h2c_q.size() != 0};
      exp_rd  = 8'h00;
      if (sel && rw) begin
         case (off)
            2'd0:    exp_rd = (h2c_q.size() != 0) ? h2c_q[0] : 8'h00;
            2'd1:    exp_rd = st;
            2'd2:    exp_rd = {6'b0, irq_en};
            default: exp_rd = 8'(h2c_q.size());
         endcase
      end
      last_rdata = o_data;
      if (model_valid) begin
         check("sel", o_sel, sel);
         check("rdata", o_data, exp_rd);
         check("h2c_ready", o_h2c_ready, h_ready);
         check("c2h_valid", o_c2h_valid, c_valid);
         if (c_valid) check("c2h_data", o_c2h_data, c2h_q[0]);
         check("irq", o_irq, exp_irq);
      end
      push_h   = h2c_valid && h_ready;
      pop_c    = c_valid && c2h_ready;
      commit   = reset_n && phi2_prev && !phi2 && sel;
      cpu_pop  = commit && rw && off == 0 && h2c_q.size() != 0;
      set_unf  = commit && rw && off == 0 && h2c_q.size() == 0;
      cpu_push = commit && !rw && off == 0 && c2h_q.size() < DEPTH;
      set_ovf  = commit && !rw && off == 0 && c2h_q.size() == DEPTH;
      st_wr    = commit && !rw && off == 1;
      en_wr    = commit && !rw && off == 2;
      last_push_h = push_h;
      @(posedge clk);
      if (!reset_n) begin
         h2c_q.delete();
         c2h_q.delete();
         ovf = 0; unf = 0; irq_en = 0; phi2_prev = 0; run = 0;
         last_push_h = 0;
         model_valid = 1;
      end else begin
         if (pop_c)    host_rx.push_back(c2h_q.pop_front());
         if (cpu_push) c2h_q.push_back(wdata);
         if (cpu_pop)  void'(h2c_q.pop_front());
         if (push_h)   h2c_q.push_back(h2c_data);
         ovf = (ovf && !(st_wr && wdata[3])) || set_ovf;
         unf = (unf && !(st_wr && wdata[4])) || set_unf;
         if (en_wr) irq_en = wdata[1:0];
         phi2_prev = phi2;
         run = 1;
      end
      exp_irq = (irq_en[0] && h2c_q.size() != 0) || (irq_en[1] && c2h_q.size() == 0);
      @(negedge clk);
   endtask

   // A full CPU bus cycle: phi2 high for 'hold' clocks, then the falling edge.
   task automatic bus(input logic [15:0] a, input bit r, input logic [7:0] d, input int hold);
      addr = a; rw = r; wdata = d; phi2 = 1'b1;
      repeat (hold) tick();
      phi2 = 1'b0;
      tick();
      bus_rd = last_rdata;
      $display("bus %s addr=%h data=%h", r ? "rd" : "wr", a, r ? bus_rd : d);
      addr = 16'h0000; rw = 1'b1;
   endtask

   task automatic host_push(input logic [7:0] b);
      int n;
      h2c_valid = 1'b1; h2c_data = b; n = 0;
      do begin
         tick();
         n++;
      end while (!last_push_h && n < 20);
      if (!last_push_h) check("push_timeout", 0, 1);
      h2c_valid = 1'b0;
      $display("host push %h", b);
   endtask

   initial begin
      reset_n = 0; phi2 = 0; rw = 1; addr = 0; wdata = 0;
      h2c_data = 0; h2c_valid = 0; c2h_ready = 0;
      model_valid = 0; rand_host = 0; run = 0; phi2_prev = 0; exp_irq = 0;
      repeat (3) tick();
      reset_n = 1;
      tick();
      check("rst_ready", o_h2c_ready, 1);
      check("rst_valid", o_c2h_valid, 0);
      check("rst_irq", o_irq, 0);
      bus(BASE + 1, 1, 0, 1); check("rst_status", bus_rd, 8'h04);

      // H2C path with underflow
      host_push(8'h11); host_push(8'h22); host_push(8'h33);
      bus(BASE + 3, 1, 0, 1); check("count3", bus_rd, 8'd3);
      bus(BASE, 1, 0, 1); check("h2c_rd0", bus_rd, 8'h11);
      bus(BASE, 1, 0, 2); check("h2c_rd1", bus_rd, 8'h22);
      bus(BASE, 1, 0, 1); check("h2c_rd2", bus_rd, 8'h33);
      bus(BASE, 1, 0, 1); check("h2c_empty_rd", bus_rd, 8'h00);
      bus(BASE + 1, 1, 0, 1); check("unf_set", bus_rd, 8'h14);
      bus(BASE + 1, 0, 8'h10, 1);
      bus(BASE + 1, 1, 0, 1); check("unf_clr", bus_rd, 8'h04);

      // Fill H2C, hold the extra byte, pop once, check wrap order
      for (int i = 0; i < DEPTH; i++) host_push(8'hA0 + 8'(i));
      h2c_valid = 1'b1; h2c_data = 8'hA0 + 8'(DEPTH);
      tick();
      check("full_ready", o_h2c_ready, 0);
      check("full_held", last_push_h, 0);
      bus(BASE, 1, 0, 1); check("fill_rd0", bus_rd, 8'hA0);
      tick();
      check("ninth_acc", last_push_h, 1);
      h2c_valid = 1'b0;
      for (int i = 1; i <= DEPTH; i++) begin
         bus(BASE, 1, 0, 1); check("fill_order", bus_rd, 8'hA0 + 8'(i));
      end

      // C2H overflow
      c2h_ready = 1'b0;
      for (int i = 0; i <= DEPTH; i++) bus(BASE, 0, 8'(i), 1);
      bus(BASE + 1, 1, 0, 1); check("ovf_status", bus_rd, 8'h0A);
      host_rx.delete();
      c2h_ready = 1'b1;
      repeat (12) tick();
      c2h_ready = 1'b0;
      check("rx_count", host_rx.size(), DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
         if (i < host_rx.size()) check("rx_order", host_rx[i], 8'(i));
      end
      bus(BASE + 1, 1, 0, 1); check("ovf_drained", bus_rd, 8'h0C);
      bus(BASE + 1, 0, 8'h08, 1);
      bus(BASE + 1, 1, 0, 1); check("ovf_clr", bus_rd, 8'h04);

      // Single commit on a long phi2, and no effect outside the window
      host_push(8'h55); host_push(8'h66);
      bus(BASE, 1, 0, 5); check("long_rd", bus_rd, 8'h55);
      bus(BASE + 3, 1, 0, 1); check("long_count", bus_rd, 8'd1);
      addr = BASE + 4; rw = 1'b0; #1;
      check("outside_sel", o_sel, 0);
      bus(BASE + 4, 0, 8'hEE, 2);
      check("outside_nopush", o_c2h_valid, 0);
      bus(BASE + 3, 1, 0, 1); check("outside_count", bus_rd, 8'd1);
      bus(BASE, 1, 0, 1); check("last_rd", bus_rd, 8'h66);

      // IRQ
      bus(BASE + 2, 0, 8'h01, 1);
      check("irq_idle", o_irq, 0);
      host_push(8'h77);
      check("irq_h2c", o_irq, 1);
      bus(BASE, 1, 0, 1); check("irq_rd", bus_rd, 8'h77);
      check("irq_h2c_off", o_irq, 0);
      bus(BASE + 2, 0, 8'h02, 1);
      check("irq_c2h_empty", o_irq, 1);
      bus(BASE, 0, 8'h99, 1);
      check("irq_c2h_off", o_irq, 0);
      c2h_ready = 1'b1; repeat (2) tick(); c2h_ready = 1'b0;
      check("irq_c2h_back", o_irq, 1);
      bus(BASE + 2, 0, 8'h00, 1);

      // Reset mid-operation with a bus cycle in flight across release
      host_push(8'h01); host_push(8'h02); host_push(8'h03);
      bus(BASE, 0, 8'h42, 1);
      addr = BASE; rw = 1'b1; phi2 = 1'b1;
      tick();
      reset_n = 0; tick(); tick();
      reset_n = 1; phi2 = 1'b0;
      tick();
      check("mid_ready", o_h2c_ready, 1);
      check("mid_valid", o_c2h_valid, 0);
      check("mid_irq", o_irq, 0);
      addr = 0;
      bus(BASE + 3, 1, 0, 1); check("mid_count", bus_rd, 8'd0);
      bus(BASE + 1, 1, 0, 1); check("mid_status", bus_rd, 8'h04);

      // Randomized traffic
      rand_host = 1;
      for (int k = 0; k < 400; k++) begin
         int op;
         op = int'($urandom_range(0, 9));
         if ($urandom_range(0, 99) == 0) begin
            reset_n = 0; tick(); reset_n = 1; tick();
         end else if (op < 6) begin
            bus(BASE + 16'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                8'($urandom), int'($urandom_range(1, 3)));
         end else begin
            repeat ($urandom_range(1, 3)) tick();
         end
      end
      rand_host = 0; h2c_valid = 0; c2h_ready = 0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_mailbox.md
# bus_mailbox

- External-bus responder that gives the 6502 a byte-wide, bidirectional mailbox to an on-board host stream.
- Connects to the MCU's external bus pins (address, write data, rw, phi2) and drives the external read-data input.
- Provides two FIFOs:
  - host-to-CPU (H2C): host writes with valid/ready; CPU reads through a memory-mapped DATA register.
  - CPU-to-host (C2H): CPU writes DATA; host drains with valid/ready.
- Adds status, interrupt-enable and count registers, plus a level IRQ output for the MCU's external IRQ line.

## Interface

Parameters:
- BASE_ADDR, 16'hB000, base of the 4-byte register window; must avoid the MCU's internal 16'hA000–16'hA047 region.
- FIFO_DEPTH, 8, entries per FIFO; power of two, at least 2.

Ports:
- i_clk  in  1  system clock; the only clock.
- i_reset_n  in  1  synchronous, active-low reset.
- i_phi2  in  1  CPU phi2 from the MCU, sampled on i_clk.
- i_addr  in  16  CPU bus address.
- i_rw  in  1  1 = read, 0 = write.
- i_data  in  8  CPU write data.
- o_data  out  8  read data to the MCU's external bus input.
- o_sel  out  1  address falls in the register window.
- i_h2c_data  in  8  host byte.
- i_h2c_valid  in  1  host byte valid.
- o_h2c_ready  out  1  H2C can accept.
- o_c2h_data  out  8  C2H head byte.
- o_c2h_valid  out  1  C2H non-empty.
- i_c2h_ready  in  1  host accepts C2H byte.
- o_irq  out  1  active-high interrupt request.

## Operation

Register map (offset from BASE_ADDR):
- **+0 DATA**
  - Read returns the H2C head and pops it.
  - If H2C is empty, a read returns 8'h00, does not pop, and sets UNDERFLOW.
  - Write pushes into C2H. If C2H is full, the byte is dropped and OVERFLOW is set.
- **+1 STATUS** (read)
  - bit0 H2C non-empty; bit1 C2H full; bit2 C2H empty; bit3 OVERFLOW (sticky); bit4 UNDERFLOW (sticky); bits7:5 read 0.
  - Write: 1 in bit3 or bit4 clears that flag; all other bits ignored.
- **+2 IRQ_EN** (R/W)
  - bit0 enables the IRQ on H2C non-empty; bit1 enables the IRQ on C2H empty; other bits read 0.
- **+3 COUNT** (read): H2C occupancy, zero-extended. Writes are ignored.

Bus access rules:
- o_sel is combinational: i_addr is in BASE_ADDR..BASE_ADDR+3.
- o_data is combinational. It shows the selected register when o_sel && i_rw, otherwise 8'h00. The value reflects the current head/state, with no pop preview.
- Side effects (pop, push, W1C, IRQ_EN write) commit only on a phi2 falling edge:
  - detected as phi2_q == 1 && i_phi2 == 0, with phi2_q registered on i_clk;
  - require o_sel at the same i_clk edge;
  - give exactly one commit per bus cycle, however many i_clk cycles phi2 spans.

Host-side rules:
- H2C push on i_h2c_valid && o_h2c_ready at the i_clk edge; o_h2c_ready = !h2c_full.
- C2H pop on o_c2h_valid && i_c2h_ready; o_c2h_data = C2H head.
- A push and a pop on the same FIFO at the same edge both occur; occupancy is unchanged.
- Ready and valid are computed from state before that edge. A full FIFO never accepts, even if popped the same cycle.
- A DATA write that finds C2H full, while the host pops C2H in the same cycle, is still dropped and still sets OVERFLOW.

IRQ:
- o_irq is registered: (IRQ_EN[0] && h2c_nonempty) || (IRQ_EN[1] && c2h_empty), from the state after the current edge.

## Timing

Reset (i_reset_n low at an i_clk edge):
- Both FIFOs emptied; pointers and counts 0; OVERFLOW = UNDERFLOW = 0; IRQ_EN = 0; phi2_q = 0; o_irq = 0.
- While i_reset_n is low, o_h2c_ready = 0 and o_c2h_valid = 0.
- From the first edge after release: o_h2c_ready = 1.

Reset mid-operation:
- All queued bytes are lost.
- A bus cycle in flight across release is not committed, because phi2_q starts at 0.

Latencies:
- Host push to STATUS bit0 and COUNT visible: next i_clk cycle.
- Host push to o_irq (with IRQ_EN[0] set): 1 cycle later.
- CPU pop commit to the next head appearing on o_data: the cycle after the phi2 falling edge.
- CPU DATA write to o_c2h_valid: the cycle after the commit edge.

Pointers and counts:
- Pointers are log2(FIFO_DEPTH) bits, wrapping modulo depth.
- Counts are log2(FIFO_DEPTH)+1 bits; full when count == FIFO_DEPTH.

## Test plan

- **Reset:** assert reset with FIFOs holding data, release → o_h2c_ready 1, o_c2h_valid 0, o_irq 0, COUNT 0, STATUS 8'h04.
- **H2C path:** host pushes 8'h11, 8'h22, 8'h33; CPU reads COUNT → 3; three DATA reads → 8'h11, 8'h22, 8'h33; a fourth read → 8'h00 with STATUS bit4 set; write 8'h10 to STATUS → bit4 clears.
- **Fill H2C:** push FIFO_DEPTH+1 bytes with valid held → o_h2c_ready drops after 8 bytes; 9th byte is held by the host, not lost. One CPU pop → ready returns; 9th byte accepted; pointer wrap verified by order.
- **C2H overflow:** i_c2h_ready = 0; CPU writes 9 bytes 8'h00..8'h08 → STATUS bit1 = 1, bit3 = 1. Raise ready → host receives 8'h00..8'h07 in order; STATUS ends at 8'h0C.
- **Single commit:** phi2 high for 5 i_clk cycles on a DATA read with 2 bytes queued → exactly one pop, COUNT goes 2 → 1. An access outside the window (BASE_ADDR+4) → o_sel 0, no side effect.
- **IRQ:** write IRQ_EN = 8'h01, host pushes a byte → o_irq rises 1 cycle after the push and falls after the CPU pop. Write IRQ_EN = 8'h02 → o_irq = 1 while C2H is empty, 0 after a CPU DATA write.
